// File: rtl/pmp_scan_checker.sv
// rtl/pmp_scan_checker.sv - multi-entry sequential PMP checker scanning ENTRIES_PER_CYCLE entries per clock
module pmp_scan_checker #(
    parameter int XLEN              = 32,
    parameter int NUM_ENTRIES       = 16,
    parameter int ENTRIES_PER_CYCLE = 4,
    localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [XLEN-1:0]             req_addr,
    input  logic [1:0]                  req_size,
    input  logic [1:0]                  req_type,
    input  logic                        req_priv_m,
    input  logic [8*NUM_ENTRIES-1:0]    pmpcfg,
    input  logic [XLEN*NUM_ENTRIES-1:0] pmpaddr,
    output logic                        busy,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic                        resp_allow,
    output logic                        resp_hit,
    output logic                        resp_part,
    output logic [IW-1:0]               resp_entry
);
    localparam int NG = NUM_ENTRIES / ENTRIES_PER_CYCLE;
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;
    // Extra headroom bits so NA4/NAPOT/TOR upper bounds never wrap.
    localparam int W  = XLEN + 4;

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grp_q;
    logic [XLEN-1:0] addr_q;
    logic [1:0]      size_q;
    logic [1:0]      type_q;
    logic            priv_q;

    logic [7:0]      cfg_arr  [NUM_ENTRIES];
    logic [XLEN-1:0] addr_arr [NUM_ENTRIES];

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            cfg_arr[i]  = pmpcfg[8*i +: 8];
            addr_arr[i] = pmpaddr[XLEN*i +: XLEN];
        end
    end

    logic [IW-1:0]   idx;
    logic [7:0]      cfg;
    logic [XLEN-1:0] a_cur, a_prev;
    logic [W-1:0]    lo, hi, m, acc_lo, acc_hi;
    logic            en, ov, full;
    logic            found, g_full;
    logic [IW-1:0]   g_idx;
    logic [7:0]      g_cfg;
    logic            perm, allow_d, last_grp;

    // Evaluate the current group; the lowest overlapping index in the group decides.
    always_comb begin
        acc_lo = W'(addr_q);
        acc_hi = acc_lo + (W'(1) << size_q);
        idx    = '0;
        cfg    = '0;
        a_cur  = '0;
        a_prev = '0;
        lo     = '0;
        hi     = '0;
        m      = '0;
        en     = 1'b0;
        ov     = 1'b0;
        full   = 1'b0;
        found  = 1'b0;
        g_full = 1'b0;
        g_idx  = '0;
        g_cfg  = '0;
        for (int j = 0; j < ENTRIES_PER_CYCLE; j++) begin
            idx    = IW'(grp_q) * IW'(ENTRIES_PER_CYCLE) + IW'(j);
            cfg    = cfg_arr[idx];
            a_cur  = addr_arr[idx];
            a_prev = (idx == '0) ? '0 : addr_arr[idx - IW'(1)];
            m      = '0;
            case (cfg[4:3])
                2'b01: begin
                    lo = W'(a_prev) << 2;
                    hi = W'(a_cur) << 2;
                    en = (lo < hi);
                end
                2'b10: begin
                    lo = W'(a_cur) << 2;
                    hi = lo + W'(4);
                    en = 1'b1;
                end
                2'b11: begin
                    // m has ones in the trailing-ones run plus the first zero above it.
                    m  = W'(a_cur) ^ (W'(a_cur) + W'(1));
                    lo = (W'(a_cur) & ~m) << 2;
                    hi = lo + ((m + W'(1)) << 2);
                    en = 1'b1;
                end
                default: begin
                    lo = '0;
                    hi = '0;
                    en = 1'b0;
                end
            endcase
            ov   = en && (acc_lo < hi) && (acc_hi > lo);
            full = (acc_lo >= lo) && (acc_hi <= hi);
            if (ov && !found) begin
                found  = 1'b1;
                g_full = full;
                g_idx  = idx;
                g_cfg  = cfg;
            end
        end
    end

    always_comb begin
        case (type_q)
            2'b00:   perm = g_cfg[0];
            2'b10:   perm = g_cfg[2];
            default: perm = g_cfg[1];
        endcase
        allow_d  = g_full & ((priv_q & ~g_cfg[7]) | perm);
        last_grp = (grp_q == GW'(NG - 1));
    end

    assign req_ready  = (state_q == IDLE) && !flush;
    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == RESP);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid && req_ready) state_d = SCAN;
            SCAN:    if (found || last_grp) state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grp_q      <= '0;
            addr_q     <= '0;
            size_q     <= '0;
            type_q     <= '0;
            priv_q     <= 1'b0;
            resp_allow <= 1'b0;
            resp_hit   <= 1'b0;
            resp_part  <= 1'b0;
            resp_entry <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid && req_ready) begin
                addr_q <= req_addr;
                size_q <= req_size;
                type_q <= req_type;
                priv_q <= req_priv_m;
                grp_q  <= '0;
            end
            if (state_q == SCAN && !flush) begin
                grp_q <= grp_q + GW'(1);
                if (found || last_grp) begin
                    resp_allow <= found ? allow_d : priv_q;
                    resp_hit   <= found;
                    resp_part  <= found & ~g_full;
                    resp_entry <= found ? g_idx : '0;
                end
            end
        end
    end
endmodule
